gate_test_sequencer: RTL
========================

GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 SHALL have parameter DWELL, default 4: cycles each input vector is held, legal range 1..16.
REQ-002 SHALL have parameter NVEC, default 8: number of vectors applied, fixed at 8 for the 3-input gate datapath.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that begins a sweep.
REQ-006 SHALL have port abort, input, 1 bit: terminates a sweep in progress.
REQ-007 SHALL have port vec_out, output, 3 bits: drives the gate block inputs; bit0=in1, bit1=in2, bit2=in3.
REQ-008 SHALL have port dut_out, input, 3 bits: gate block outputs; bit0=out1, bit1=out2, bit2=out3.
REQ-009 SHALL have port exp_out, input, 3 bits: expected outputs for the current vec_out, from the reference model.
REQ-010 SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-012 SHALL have port err_cnt, output, 4 bits: number of mismatching vectors in the current or last sweep.
REQ-013 SHALL have port err_vec, output, 8 bits: bit k set when vector k mismatched.

Function
REQ-014 SHALL implement a state machine with states IDLE, APPLY and DONE.
REQ-015 IDLE: vec_out=0, busy=0; when start=1, SHALL go to APPLY next cycle and clear err_cnt, err_vec, vector index and dwell counter on that same edge.
REQ-016 APPLY: busy=1, vec_out=vector index (0..7); dwell counter SHALL count 0..DWELL-1.
REQ-017 In APPLY with dwell counter == DWELL-1 (the sample cycle), SHALL compare dut_out with exp_out; on any bit difference, SHALL increment err_cnt by 1 and set err_vec[index] at that edge.
REQ-018 Sample cycle with index < 7: SHALL increment index and reset dwell counter to 0, staying in APPLY.
REQ-019 Sample cycle with index == 7: SHALL go to DONE; vec_out returns to 0 in DONE.
REQ-020 DONE: done=1 and busy=0 for exactly one cycle, then IDLE unconditionally.
REQ-021 Latency: busy high exactly 8*DWELL cycles; done asserts the cycle after the last sample cycle.
REQ-022 DWELL=1: every APPLY cycle is a sample cycle; vec_out SHALL advance each cycle.
REQ-023 err_cnt and err_vec SHALL hold after DONE until the next accepted start; err_cnt cannot exceed 8, so no saturation is required.
REQ-024 start while in APPLY or DONE SHALL be ignored.
REQ-025 abort=1 in APPLY SHALL go to IDLE next cycle with vec_out=0 and no done pulse; err_cnt/err_vec keep partial results.
REQ-026 abort and a sample cycle in the same cycle: abort SHALL win; that sample is discarded.
REQ-027 abort and start together in IDLE: start SHALL be ignored.
REQ-028 Outputs vec_out, busy, done, err_cnt and err_vec SHALL be registered, with no combinational path from any input.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, vec_out=0, busy=0, done=0, err_cnt=0, err_vec=0, index=0 and dwell counter=0, regardless of state.
REQ-030 rst SHALL take priority over start and abort; reset mid-sweep SHALL produce no done pulse.

Verification
REQ-031 DWELL=4, exp_out tied to a correct model, start pulse -> vec_out steps 0..7 every 4 cycles, busy high 32 cycles, done pulse at cycle 33, err_cnt=0, err_vec=0x00.
REQ-032 DWELL=4, exp_out forced wrong on vectors 3 and 5 -> err_cnt=2, err_vec=0x28, values held until the next start.
REQ-033 DWELL=1, all vectors wrong -> vec_out advances every cycle, busy 8 cycles, err_cnt=8, err_vec=0xFF.
REQ-034 abort during vector 2, sampled in the same cycle with a mismatch -> IDLE next cycle, no done, err_vec bit2 clear.
REQ-035 start pulses while busy; rst asserted mid-sweep at vector 6 -> extra starts have no effect; after rst all outputs are 0, no done pulse, and a subsequent start runs a full 32-cycle sweep.

Source files
------------

// File: rtl/gate_test_sequencer.sv
// Sweeps the eight 3-bit input vectors of a gate block, holding each for DWELL
// cycles and logging which vectors produced outputs that differ from the reference.
module gate_test_sequencer #(
    parameter int DWELL = 4,
    parameter int NVEC  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic [2:0] vec_out,
    input  logic [2:0] dut_out,
    input  logic [2:0] exp_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] err_cnt,
    output logic [7:0] err_vec
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_DONE
    } state_t;

    localparam int             DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]  LAST_DWELL = DW'(DWELL - 1);
    localparam logic [2:0]     LAST_IDX   = 3'(NVEC - 1);

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    err_cnt_d;
    logic [7:0]    err_vec_d;
    logic [2:0]    vec_d;
    logic          busy_d, done_d;
    logic          sample;

    assign sample = (state_q == ST_APPLY) && (dwell_q == LAST_DWELL);

    // State, counters and the registered outputs all advance together.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // sees the pre-edge values of the others, independent of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dwell_q <= '0;
            err_cnt <= '0;
            err_vec <= '0;
            vec_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            err_cnt <= err_cnt_d;
            err_vec <= err_vec_d;
            vec_out <= vec_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a hold default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        dwell_d   = dwell_q;
        err_cnt_d = err_cnt;
        err_vec_d = err_vec;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d   = ST_APPLY;
                    idx_d     = '0;
                    dwell_d   = '0;
                    err_cnt_d = '0;
                    err_vec_d = '0;
                end
            end
            ST_APPLY: begin
                // Abort outranks a coincident sample, which is then dropped.
                if (abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    dwell_d = '0;
                end else if (sample) begin
                    if (dut_out != exp_out) begin
                        err_cnt_d        = err_cnt + 4'd1;
                        err_vec_d[idx_q] = 1'b1;
                    end
                    dwell_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values are decoded from the next state so the registers line up
    // with the state they describe.
    always_comb begin
        vec_d  = (state_d == ST_APPLY) ? idx_d : 3'd0;
        busy_d = (state_d == ST_APPLY);
        done_d = (state_d == ST_DONE);
    end

endmodule
